prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Runtime-programmable clock divider and tick generator, the parametrised successor to the fixed-divisor divider used for pixel and timing clocks in the VGA path. It produces a 50% duty divided clock whose half-period is set by a register-loadable divisor. It also produces single-cycle rise/fall strobes that downstream VGA timing logic uses as clock enables. Divisor changes are glitch-free: they are applied only at a full-period boundary or on an explicit restart.

## Interface
Parameters:
- WIDTH, 16: width of the counter and divisor.
- DEFAULT_DIV, 1: active divisor after reset. Must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst_n  input  1  synchronous, active-low reset; sampled on posedge clk.
- en  input  1  count enable; when low, all state holds.
- restart  input  1  single-cycle strobe that forces phase back to the start of the low half-period.
- div_value  input  WIDTH  new divisor D; sampled when div_load=1.
- div_load  input  1  single-cycle strobe that captures div_value into the shadow register.
- div_clk  output  1  divided clock; registered; half-period is D+1 clk cycles.
- tick_rise  output  1  one-cycle strobe, high in the same cycle div_clk first reads 1.
- tick_fall  output  1  one-cycle strobe, high in the same cycle div_clk first reads 0 after a high phase.
- cur_div  output  WIDTH  active divisor.
- pending  output  1  a shadow divisor is waiting to be applied.

## Operation
- State: cnt[WIDTH-1:0], div_clk, active[WIDTH-1:0] (drives cur_div), shadow[WIDTH-1:0], pending, tick_rise, tick_fall.
- Reset (rst_n=0 at posedge):
  - cnt=0, div_clk=0, tick_rise=0, tick_fall=0, pending=0.
  - active=DEFAULT_DIV, shadow=DEFAULT_DIV.
  - Reset has priority over every other input.
- Priority below reset: restart, then en, then idle hold.
- Normal count (en=1, restart=0):
  - If cnt==active: cnt<=0 and div_clk toggles. Otherwise cnt<=cnt+1.
  - On a 0→1 toggle, tick_rise<=1. On a 1→0 toggle, tick_fall<=1. Both strobes are 0 in every other cycle.
- Full-period boundary: the cycle in which cnt==active and div_clk==1, i.e. the falling toggle. If pending=1 in that cycle, active<=shadow and pending<=0. The new divisor governs the next low phase onward.
- Load:
  - div_load=1 sets shadow<=div_value and pending<=1. This is independent of en.
  - A load while already pending overwrites shadow; last write wins.
  - Load coincident with a boundary: active takes the old shadow value (if pending), shadow takes the new value, and pending stays 1.
- Restart:
  - cnt<=0, div_clk<=0, and both ticks are 0 (no tick_fall even if div_clk was 1).
  - If pending=1, active<=shadow and pending<=0.
  - If div_load is also asserted, the new value goes to shadow and pending=1. Active takes the previous shadow.
- en=0 (and restart=0): cnt, div_clk and active hold, and both ticks are 0. Loads are still accepted.
- Arithmetic:
  - cnt is compared for equality only and never exceeds active.
  - If active changes only at a boundary or restart, cnt is 0 at that point, so it cannot overshoot.
  - D=0 is legal: div_clk toggles every cycle, giving a period of 2 clk.
  - D=2^WIDTH−1 is legal: half-period is 2^WIDTH.

## Timing
- All outputs are registered, and there is no combinational path from input to output.
- Period is 2·(active+1) clk cycles with exactly 50% duty.
- After reset release, the first div_clk rise occurs active+1 enabled cycles later. With D=2, div_clk=1 from cycle 3 and the period is 6.
- div_load to pending=1 takes 1 cycle. cur_div updates on the cycle after the boundary edge.
- restart takes effect on the next edge. cnt counts from 0 in the following cycle.
- Reset mid-operation produces no tick on the reset edge, and outputs read reset values in the next cycle.

## Test plan
- Defaults (DEFAULT_DIV=1), en=1 for 16 cycles → div_clk period 4, duty 2/2, tick_rise every 4 cycles aligned with div_clk's first high cycle, cur_div=1.
- div_load D=0 then D=65535 (WIDTH=16) → with D=0, period 2 and a tick every cycle alternating rise/fall. With D=65535, half-period 65536. No glitch at either switch.
- D=3 running, then load 1 mid-high-phase, then load 5 before the boundary → pending=1. At the falling boundary cur_div=5 (last write wins), pending=0, and the next low phase is 6 cycles.
- Load 7 in the exact boundary cycle while shadow=2 is pending → cur_div=2 and pending stays 1. At the next boundary cur_div=7.
- D=2: drop en for 5 cycles mid-high-phase, then restart while high with a load pending → during the en drop, div_clk holds 1, cnt is frozen and no ticks occur. On restart, div_clk=0 next cycle, no tick_fall, cur_div is updated immediately and pending=0.
- Assert rst_n=0 for 1 cycle mid-period with pending=1 → div_clk=0, cnt=0, cur_div=DEFAULT_DIV, pending=0, no ticks. The first rise occurs DEFAULT_DIV+1 cycles after release.

Source files
------------

// File: rtl/prog_clock_divider_if.sv
// rtl/prog_clock_divider_if.sv - control/status bundle for prog_clock_divider
//
// Purpose: groups the divider's control inputs and status outputs.
// master: drives en, restart, div_value, div_load; observes the outputs.
// slave : the divider itself.
// Signals:
//   en         count enable
//   restart    strobe, restart phase at start of low half-period
//   div_value  new divisor, captured when div_load=1
//   div_load   strobe, capture div_value into the shadow register
//   div_clk    divided clock (half-period = D+1 clk cycles)
//   tick_rise  one-cycle strobe with div_clk's first high cycle
//   tick_fall  one-cycle strobe with div_clk's first low cycle after high
//   cur_div    active divisor
//   pending    shadow divisor waiting for the next period boundary
interface prog_clock_divider_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             restart;
   logic [WIDTH-1:0] div_value;
   logic             div_load;
   logic             div_clk;
   logic             tick_rise;
   logic             tick_fall;
   logic [WIDTH-1:0] cur_div;
   logic             pending;

   modport master (
      output en, restart, div_value, div_load,
      input  div_clk, tick_rise, tick_fall, cur_div, pending
   );

   modport slave (
      input  en, restart, div_value, div_load,
      output div_clk, tick_rise, tick_fall, cur_div, pending
   );
endinterface

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - runtime-programmable 50% duty clock divider with tick strobes
//
// Purpose: divides clk by 2*(D+1) with exactly 50% duty and emits single-cycle
// rise/fall strobes usable as clock enables. A new divisor is staged in a
// shadow register and only takes effect at a full-period boundary (falling
// toggle) or on restart, so div_clk never produces a short phase.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    prog_clock_divider_if.slave (control inputs / registered outputs)
module prog_clock_divider #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prog_clock_divider_if.slave   bus
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt_q,       cnt_d;
   logic             div_clk_q,   div_clk_d;
   logic [WIDTH-1:0] active_q,    active_d;
   logic [WIDTH-1:0] shadow_q,    shadow_d;
   logic             pending_q,   pending_d;
   logic             tick_rise_q, tick_rise_d;
   logic             tick_fall_q, tick_fall_d;

   always_comb begin
      cnt_d       = cnt_q;
      div_clk_d   = div_clk_q;
      active_d    = active_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      tick_rise_d = 1'b0;
      tick_fall_d = 1'b0;

      if (bus.restart) begin
         // Restart always lands at the start of a low phase, so it is also a
         // safe point to adopt a staged divisor. No tick is emitted.
         cnt_d     = '0;
         div_clk_d = 1'b0;
         if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
      end else if (bus.en) begin
         if (cnt_q == active_q) begin
            cnt_d     = '0;
            div_clk_d = ~div_clk_q;
            if (!div_clk_q) begin
               tick_rise_d = 1'b1;
            end else begin
               // Falling toggle = full-period boundary; cnt restarts at 0 so
               // switching active here can never leave cnt above it.
               tick_fall_d = 1'b1;
               if (pending_q) begin
                  active_d  = shadow_q;
                  pending_d = 1'b0;
               end
            end
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end

      // Applied last: a load in the same cycle as a boundary/restart lets
      // active take the old shadow while the new value stays pending.
      if (bus.div_load) begin
         shadow_d  = bus.div_value;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         div_clk_q   <= 1'b0;
         active_q    <= DEF_DIV;
         shadow_q    <= DEF_DIV;
         pending_q   <= 1'b0;
         tick_rise_q <= 1'b0;
         tick_fall_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         div_clk_q   <= div_clk_d;
         active_q    <= active_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         tick_rise_q <= tick_rise_d;
         tick_fall_q <= tick_fall_d;
      end
   end

   assign bus.div_clk   = div_clk_q;
   assign bus.tick_rise = tick_rise_q;
   assign bus.tick_fall = tick_fall_q;
   assign bus.cur_div   = active_q;
   assign bus.pending   = pending_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

   localparam int WIDTH = 16;
   localparam int DEF   = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prog_clock_divider_if #(.WIDTH(WIDTH)) bus ();

   prog_clock_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference: a half-phase lasts (act+1) enabled cycles; 'done' counts the
   // enabled cycles already spent in the current half-phase.
   int m_level, m_done, m_act, m_shad, m_pend, m_rise, m_fall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit rs, input bit ld, input int v);
      m_rise = 0;
      m_fall = 0;
      if (!r) begin
         m_level = 0; m_done = 0; m_act = DEF; m_shad = DEF; m_pend = 0;
         return;
      end
      if (rs) begin
         m_level = 0;
         m_done  = 0;
         if (m_pend != 0) begin m_act = m_shad; m_pend = 0; end
      end else if (e) begin
         m_done++;
         if (m_done == m_act + 1) begin
            m_done  = 0;
            m_level = 1 - m_level;
            if (m_level == 1) m_rise = 1;
            else begin
               m_fall = 1;
               if (m_pend != 0) begin m_act = m_shad; m_pend = 0; end
            end
         end
      end
      if (ld) begin m_shad = v; m_pend = 1; end
   endtask

   task automatic cyc(input bit r, input bit e, input bit rs, input bit ld, input int v);
      rst_n         = r;
      bus.en        = e;
      bus.restart   = rs;
      bus.div_load  = ld;
      bus.div_value = WIDTH'(v);
      @(posedge clk);
      #1;
      model_step(r, e, rs, ld, v);
      chk("div_clk",   32'(bus.div_clk),   32'(m_level));
      chk("tick_rise", 32'(bus.tick_rise), 32'(m_rise));
      chk("tick_fall", 32'(bus.tick_fall), 32'(m_fall));
      chk("cur_div",   32'(bus.cur_div),   32'(m_act));
      chk("pending",   32'(bus.pending),   32'(m_pend));
   endtask

   // Run enabled cycles until a tick_fall is seen; expired bound is a failure.
   task automatic run_to_fall(input int bound, input string tag);
      bit seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (bus.tick_fall) seen = 1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int n;
      int rises;
      bit r, e, rs, ld;
      int v;

      m_level = 0; m_done = 0; m_act = DEF; m_shad = DEF; m_pend = 0;

      // Reset state and default divisor: period 4, rise at cycles 2, 6, 10, 14
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("rst_div_clk", 32'(bus.div_clk), 32'd0);
      chk("rst_cur_div", 32'(bus.cur_div), 32'd1);
      chk("rst_pending", 32'(bus.pending), 32'd0);
      rises = 0;
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (bus.tick_rise) begin
            rises++;
            chk("def_rise_pos", 32'(i % 4), 32'd2);
         end
         chk("def_level", 32'(bus.div_clk), 32'((i % 4) >= 2));
      end
      chk("def_rises", 32'(rises), 32'd4);

      // D=0: a tick every cycle, then switch to D=65535 and measure low phase
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 1, 0, 0);
      chk("d0_active", 32'(bus.cur_div), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 0, 0, 0);
         chk("d0_tick", 32'(bus.tick_rise ^ bus.tick_fall), 32'd1);
      end
      cyc(1, 1, 0, 1, 65535);
      if (!bus.tick_fall) run_to_fall(4, "big_boundary");
      chk("big_active", 32'(bus.cur_div), 32'd65535);
      n = 1;
      for (int i = 0; i < 70000 && !bus.div_clk; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (!bus.div_clk) n++;
      end
      chk("big_low_len", 32'(n), 32'd65536);

      // D=3, load 1 mid-high then 5: last write wins at the boundary, low phase 6
      cyc(1, 1, 1, 1, 3);
      cyc(1, 1, 1, 0, 0);
      for (int i = 0; i < 20 && !(m_level == 1 && m_done == 1); i++) cyc(1, 1, 0, 0, 0);
      chk("mid_high", 32'(bus.div_clk), 32'd1);
      cyc(1, 1, 0, 1, 1);
      cyc(1, 1, 0, 1, 5);
      chk("lw_pending", 32'(bus.pending), 32'd1);
      run_to_fall(10, "lw_boundary");
      chk("lw_cur_div", 32'(bus.cur_div), 32'd5);
      chk("lw_pend_clr", 32'(bus.pending), 32'd0);
      n = 1;
      for (int i = 0; i < 20 && !bus.div_clk; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (!bus.div_clk) n++;
      end
      chk("lw_low_len", 32'(n), 32'd6);

      // Load 7 exactly in the boundary cycle while 2 is pending
      cyc(1, 1, 0, 1, 2);
      for (int i = 0; i < 40 && !(m_level == 1 && m_done == m_act); i++) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 7);
      chk("bnd_fall", 32'(bus.tick_fall), 32'd1);
      chk("bnd_cur_div", 32'(bus.cur_div), 32'd2);
      chk("bnd_pending", 32'(bus.pending), 32'd1);
      run_to_fall(20, "bnd_next");
      chk("bnd_cur_div2", 32'(bus.cur_div), 32'd7);

      // D=2: en dropped mid-high, then restart while high with a load pending
      cyc(1, 1, 1, 1, 2);
      cyc(1, 1, 1, 0, 0);
      for (int i = 0; i < 20 && !(m_level == 1 && m_done == 1); i++) cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 0, (i == 2), 4);
         chk("hold_clk", 32'(bus.div_clk), 32'd1);
         chk("hold_tick", 32'(bus.tick_rise | bus.tick_fall), 32'd0);
      end
      chk("hold_pend", 32'(bus.pending), 32'd1);
      cyc(1, 1, 1, 0, 0);
      chk("rs_clk", 32'(bus.div_clk), 32'd0);
      chk("rs_nofall", 32'(bus.tick_fall), 32'd0);
      chk("rs_cur_div", 32'(bus.cur_div), 32'd4);
      chk("rs_pend", 32'(bus.pending), 32'd0);

      // Reset mid-period with a load pending
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 9);
      cyc(0, 1, 0, 0, 0);
      chk("mr_clk", 32'(bus.div_clk), 32'd0);
      chk("mr_tick", 32'(bus.tick_rise | bus.tick_fall), 32'd0);
      chk("mr_cur_div", 32'(bus.cur_div), 32'(DEF));
      chk("mr_pend", 32'(bus.pending), 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("mr_first0", 32'(bus.div_clk), 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("mr_rise", 32'(bus.tick_rise), 32'd1);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 199) != 0);
         e  = ($urandom_range(0, 9) != 0);
         rs = ($urandom_range(0, 39) == 0);
         ld = ($urandom_range(0, 14) == 0);
         v  = $urandom_range(0, 6);
         cyc(r, e, rs, ld, v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
